// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one uart_tx core among NUM_REQ byte producers.
//   Exactly one byte is in flight at a time: a grant raises tx_start and the
//   arbiter waits for the core to report busy, then for busy to fall again,
//   before the next arbitration.
// Ports
//   clk, rst     : clock and asynchronous active-high reset
//   req_valid    : per-requester byte available
//   req_data     : byte i at req_data[8*i+7:8*i]
//   req_ready    : one-cycle pulse when byte i is accepted
//   tx_start     : start request to uart_tx, held until busy rises or timeout
//   tx_data      : byte for uart_tx, captured at grant
//   tx_busy      : uart_tx busy flag
//   grant_id     : index of requester owning the current/last byte
//   active       : high whenever the FSM is not idle
//   timeout_err  : one-cycle pulse when tx_busy never rose after tx_start
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int START_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic                 timeout_err
);

  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    SEND
  } state_t;

  state_t               state, state_next;
  logic [ID_W-1:0]      last, last_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 tx_start_next;
  logic [7:0]           tx_data_next;
  logic [ID_W-1:0]      grant_id_next;
  logic [NUM_REQ-1:0]   req_ready_next;
  logic                 timeout_err_next;

  logic                 win_found;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W-1:0]      scan_idx;
  logic [7:0]           win_data;

  // Rotating priority scan: start just after the last winner and take the
  // first requester with valid set, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    win_data = req_data[8*int'(win_idx) +: 8];
  end

  // Next-state and registered-output logic. Request inputs are only looked at
  // in IDLE, which is what rules out a second accept while a byte is in flight.
  // The launch counter is compared before it increments, so it never wraps.
  always_comb begin
    state_next       = state;
    last_next        = last;
    cnt_next         = cnt;
    tx_start_next    = tx_start;
    tx_data_next     = tx_data;
    grant_id_next    = grant_id;
    req_ready_next   = '0;
    timeout_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && win_found) begin
          tx_data_next             = win_data;
          grant_id_next            = win_idx;
          last_next                = win_idx;
          req_ready_next[win_idx]  = 1'b1;
          tx_start_next            = 1'b1;
          cnt_next                 = '0;
          state_next               = LAUNCH;
        end
      end
      LAUNCH: begin
        // Busy takes precedence over an expiring timeout in the same cycle.
        if (tx_busy) begin
          tx_start_next = 1'b0;
          state_next    = SEND;
        end else if (cnt == CNT_LAST) begin
          tx_start_next    = 1'b0;
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      SEND: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        tx_start_next = 1'b0;
        state_next    = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything immediately; a frame
  // already running inside uart_tx is left alone and shows up as tx_busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= LAST_INIT;
      cnt         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      last        <= last_next;
      cnt         <= cnt_next;
      tx_start    <= tx_start_next;
      tx_data     <= tx_data_next;
      grant_id    <= grant_id_next;
      req_ready   <= req_ready_next;
      timeout_err <= timeout_err_next;
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Scoreboard bench for uart_tx_arbiter. Producers are queues of bytes that
//   keep valid high while non-empty; a reference model predicts the grant
//   order by round-robin over non-empty queues. A uart_tx model answers
//   tx_start with tx_busy after a programmable delay.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TMO     = 8;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 active;
  logic                 timeout_err;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_grant_q[$];
  logic [7:0] exp_frame_q[$];
  logic [7:0] prod_q[NUM_REQ][$];

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   timeout_seen = 0;
  int   model_last   = NUM_REQ - 1;
  bit   stuck        = 1'b0;
  int   delay_min    = 0;
  int   delay_max    = 5;
  int   len_min      = 1;
  int   len_max      = 6;
  logic uart_busy    = 1'b0;
  logic ext_busy     = 1'b0;

  assign tx_busy = uart_busy | ext_busy;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W),
    .START_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .timeout_err(timeout_err)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Queue bytes for one producer
  task automatic applyStimulus(input int id, input logic [7:0] data);
    prod_q[id].push_back(data);
  endtask

  // Reference model: requesters with bytes pending stay valid, so grants go
  // round-robin over non-empty queues starting after the last winner.
  task automatic buildExpected(input bit drop_first);
    int   remaining[NUM_REQ];
    int   pos[NUM_REQ];
    int   total;
    bit   first;
    exp_t e;
    total = 0;
    first = drop_first;
    for (int i = 0; i < NUM_REQ; i++) begin
      remaining[i] = prod_q[i].size();
      pos[i]       = 0;
      total       += remaining[i];
    end
    while (total > 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (model_last + k) % NUM_REQ;
        if (remaining[idx] > 0) begin
          e.id   = idx;
          e.data = prod_q[idx][pos[idx]];
          exp_grant_q.push_back(e);
          if (!first) exp_frame_q.push_back(e.data);
          first = 1'b0;
          pos[idx]++;
          remaining[idx]--;
          total--;
          model_last = idx;
          break;
        end
      end
    end
  endtask

  function automatic bit queuesEmpty();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (prod_q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic waitIdle(input int budget);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
      done = (exp_grant_q.size() == 0) && (exp_frame_q.size() == 0) &&
             !active && !uart_busy && queuesEmpty();
    end
    checkOutput("drain_in_budget", {31'd0, done}, 32'd1);
  endtask

  // Main-process changes happen just after a falling edge, after producers
  task automatic syncMain();
    @(negedge clk); #2;
  endtask

  // Producers: present the head of each queue, pop when accepted
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
        req_valid[i] = (prod_q[i].size() > 0);
        req_data[8*i +: 8] = (prod_q[i].size() > 0) ? prod_q[i][0] : 8'h00;
      end
    end
  end

  // uart_tx model: answer tx_start with busy, check the byte it would send
  initial begin
    int         d;
    int         l;
    logic [7:0] f;
    forever begin
      @(posedge clk); #1;
      if (tx_start && !stuck && !rst) begin
        d = $urandom_range(delay_max, delay_min);
        l = $urandom_range(len_max, len_min);
        for (int i = 0; i < d; i++) begin
          @(posedge clk); #1;
        end
        checkOutput("start_held_until_busy", {31'd0, tx_start}, 32'd1);
        uart_busy = 1'b1;
        checkOutput("frame_expected", {31'd0, exp_frame_q.size() > 0}, 32'd1);
        if (exp_frame_q.size() > 0) begin
          f = exp_frame_q.pop_front();
          checkOutput("uart_byte", {24'd0, tx_data}, {24'd0, f});
        end
        @(posedge clk); #1;
        checkOutput("start_drop_after_busy", {31'd0, tx_start}, 32'd0);
        for (int i = 1; i < l; i++) begin
          @(posedge clk); #1;
        end
        uart_busy = 1'b0;
      end
    end
  end

  // Grant monitor: each req_ready pulse is compared with the next prediction
  initial begin
    logic [NUM_REQ-1:0] prev_ready;
    exp_t               e;
    prev_ready = '0;
    forever begin
      @(posedge clk); #1;
      if (prev_ready != '0)
        checkOutput("ready_one_cycle", {28'd0, req_ready}, 32'd0);
      if (req_ready != '0) begin
        checkOutput("grant_expected", {31'd0, exp_grant_q.size() > 0}, 32'd1);
        if (exp_grant_q.size() > 0) begin
          e = exp_grant_q.pop_front();
          checkOutput("req_ready", {28'd0, req_ready}, 32'd1 << e.id);
          checkOutput("grant_id", {30'd0, grant_id}, e.id);
          checkOutput("tx_data", {24'd0, tx_data}, {24'd0, e.data});
          checkOutput("start_with_ready", {31'd0, tx_start}, 32'd1);
        end
      end
      if (timeout_err) timeout_seen++;
      prev_ready = req_ready;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    #3;
    checkOutput("rst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("rst_req_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("rst_active", {31'd0, active}, 32'd0);
    checkOutput("rst_grant_id", {30'd0, grant_id}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All four continuously valid: 10,11,12,13,10,11,12,13
    syncMain();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 8'h10 + 8'(i));
    buildExpected(1'b0);
    waitIdle(1000);

    // Single requester, fixed busy delay, first-grant latency
    delay_min = 3;
    delay_max = 3;
    syncMain();
    applyStimulus(0, 8'hA5);
    buildExpected(1'b0);
    @(posedge clk); #1;
    checkOutput("t1_no_early_start", {31'd0, tx_start}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_tx_start", {31'd0, tx_start}, 32'd1);
    checkOutput("t1_req_ready", {28'd0, req_ready}, 32'h1);
    checkOutput("t1_tx_data", {24'd0, tx_data}, 32'hA5);
    checkOutput("t1_grant_id", {30'd0, grant_id}, 32'd0);
    waitIdle(200);
    delay_min = 0;
    delay_max = 5;

    // Wrap: last winner 2, then 0 and 1 valid
    syncMain();
    applyStimulus(2, 8'h22);
    buildExpected(1'b0);
    waitIdle(200);
    syncMain();
    applyStimulus(1, 8'hB1);
    applyStimulus(0, 8'hB0);
    buildExpected(1'b0);
    waitIdle(200);

    // Busy stuck low: first launch times out, the other requester goes next
    syncMain();
    stuck = 1'b1;
    applyStimulus(1, 8'h5A);
    applyStimulus(3, 8'hC3);
    buildExpected(1'b1);
    n = 0;
    while (!tx_start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t4_start_seen", {31'd0, tx_start}, 32'd1);
    n = 1;
    @(posedge clk); #1;
    while (tx_start && n < 30) begin
      n++;
      @(posedge clk); #1;
    end
    stuck = 1'b0;
    checkOutput("t4_start_len", n, TMO);
    checkOutput("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
    checkOutput("t4_active_low", {31'd0, active}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t4_err_one_cycle", {31'd0, timeout_err}, 32'd0);
    waitIdle(200);

    // Busy held high externally: no grant until it falls
    syncMain();
    ext_busy = 1'b1;
    applyStimulus(2, 8'h77);
    buildExpected(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("t5_hold_off", {27'd0, req_ready, tx_start}, 32'd0);
    end
    @(negedge clk);
    ext_busy = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5_grant_ready", {28'd0, req_ready}, 32'h4);
    checkOutput("t5_grant_start", {31'd0, tx_start}, 32'd1);
    waitIdle(200);

    // Reset while the uart frame is in flight
    delay_min = 1;
    delay_max = 1;
    len_min   = 20;
    len_max   = 20;
    syncMain();
    applyStimulus(1, 8'h3C);
    buildExpected(1'b0);
    n = 0;
    while (!(uart_busy && !tx_start && active) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t6_in_send", {31'd0, uart_busy && !tx_start && active}, 32'd1);
    syncMain();
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("t6_rst_req_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("t6_rst_active", {31'd0, active}, 32'd0);
    checkOutput("t6_rst_grant_id", {30'd0, grant_id}, 32'd0);
    model_last = NUM_REQ - 1;
    syncMain();
    rst = 1'b0;
    applyStimulus(2, 8'h99);
    applyStimulus(0, 8'h42);
    buildExpected(1'b0);
    n = 0;
    while (uart_busy && n < 40) begin
      @(posedge clk); #1;
      checkOutput("t6_no_grant_while_busy", {27'd0, req_ready, tx_start}, 32'd0);
      n++;
    end
    delay_min = 0;
    delay_max = 5;
    len_min   = 1;
    len_max   = 6;
    waitIdle(300);

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      syncMain();
      for (int i = 0; i < NUM_REQ; i++) begin
        int cnt;
        cnt = $urandom_range(3, 0);
        for (int j = 0; j < cnt; j++) applyStimulus(i, 8'($urandom));
      end
      buildExpected(1'b0);
      waitIdle(1000);
    end

    checkOutput("timeout_pulses", timeout_seen, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
